// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode definitions and memaccess state encoding for the LC3 pipeline controller.
package lc3_ctrl_pkg;

  typedef enum logic [1:0] {
    MemRead  = 2'd0,
    MemInd   = 2'd1,
    MemWrite = 2'd2,
    MemIdle  = 2'd3
  } mem_state_t;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  function automatic logic is_alu(logic [3:0] op);
    return op inside {OpAdd, OpAnd, OpNot};
  endfunction

  function automatic logic is_load(logic [3:0] op);
    return op inside {OpLd, OpLdr, OpLdi, OpLea};
  endfunction

  // Loads that actually read data memory (LEA only computes an address).
  function automatic logic is_mem_load(logic [3:0] op);
    return op inside {OpLd, OpLdr, OpLdi};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {OpSt, OpStr, OpSti};
  endfunction

  function automatic logic is_ctrl(logic [3:0] op);
    return op inside {OpBr, OpJmp};
  endfunction

endpackage

// File: rtl/lc3_pipeline_ctrl_if.sv
// Control/status bundle between the LC3 datapath and its pipeline controller.
interface lc3_pipeline_ctrl_if;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  // Datapath side: supplies instruction/status, consumes enables and selects.
  modport master (
    output complete_data, complete_instr, IR, IR_Exec, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    input  br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state
  );

  // Controller side.
  modport slave (
    input  complete_data, complete_instr, IR, IR_Exec, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    output br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state
  );
endinterface

// File: rtl/lc3_bypass_logic.sv
// Combinational operand-forwarding detection between execute and the instruction behind it.
module lc3_bypass_logic
  import lc3_ctrl_pkg::*;
(
  input  logic [3:0] ir_op_i,
  input  logic [2:0] ir_dr_i,
  input  logic [2:0] ir_sr1_i,
  input  logic       ir_imm_i,
  input  logic [2:0] ir_sr2_i,
  input  logic [3:0] exec_op_i,
  input  logic [2:0] exec_dr_i,
  input  logic       mem_read_i,
  output logic       bypass_alu_1_o,
  output logic       bypass_alu_2_o,
  output logic       bypass_mem_1_o,
  output logic       bypass_mem_2_o
);

  logic op1_match;
  logic op2_match;
  logic alu_src;
  logic mem_src;

  // Register-match rules per operand, then qualify by producer; memory data wins.
  always_comb begin
    op1_match = (ir_op_i inside {OpAdd, OpAnd, OpNot, OpLdr, OpStr, OpJmp}) &&
                (exec_dr_i == ir_sr1_i);
    op2_match = ((ir_op_i inside {OpAdd, OpAnd}) && !ir_imm_i && (exec_dr_i == ir_sr2_i)) ||
                (is_store(ir_op_i) && (exec_dr_i == ir_dr_i));
    alu_src   = is_alu(exec_op_i);
    mem_src   = is_mem_load(exec_op_i) && mem_read_i;

    bypass_mem_1_o = mem_src && op1_match;
    bypass_mem_2_o = mem_src && op2_match;
    bypass_alu_1_o = alu_src && op1_match && !bypass_mem_1_o;
    bypass_alu_2_o = alu_src && op2_match && !bypass_mem_2_o;
  end

endmodule

// File: rtl/lc3_pipeline_ctrl.sv
// LC3 pipeline controller: stage enables, memaccess FSM, branch resolution and bypass selects.
module lc3_pipeline_ctrl
  import lc3_ctrl_pkg::*;
#(
  parameter logic [1:0] IDLE_ST  = 2'd3,
  parameter logic [1:0] READ_ST  = 2'd0,
  parameter logic [1:0] IND_ST   = 2'd1,
  parameter logic [1:0] WRITE_ST = 2'd2
) (
  input logic               clock,
  input logic               reset,
  lc3_pipeline_ctrl_if.slave bus
);

  mem_state_t state_q, state_d;
  logic [1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [2:0] fill_q;
  logic [3:0] ir_op, exec_op;
  logic       idle, ctrl_hold;
  logic       byp_alu_1, byp_alu_2, byp_mem_1, byp_mem_2;
  logic       unused_ir_bits;

  assign ir_op          = bus.IR[15:12];
  assign exec_op        = bus.IR_Exec[15:12];
  assign idle           = (state_q == MemIdle);
  assign ctrl_hold      = (ctrl_cnt_q != 2'd0);
  assign unused_ir_bits = ^{bus.IR[4:3], bus.IR_Exec[8:0]};

  // Memaccess next state, driven by the instruction leaving execute.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MemIdle: begin
        if (exec_op inside {OpLd, OpLdr})       state_d = MemRead;
        else if (exec_op inside {OpLdi, OpSti}) state_d = MemInd;
        else if (exec_op inside {OpSt, OpStr})  state_d = MemWrite;
      end
      MemInd: begin
        // Indirect pointer fetched; an unexpected opcode abandons the access.
        if (bus.complete_data) begin
          if (exec_op == OpLdi)      state_d = MemRead;
          else if (exec_op == OpSti) state_d = MemWrite;
          else                       state_d = MemIdle;
        end
      end
      MemRead, MemWrite: if (bus.complete_data) state_d = MemIdle;
      default: state_d = MemIdle;
    endcase
  end

  // Control-transfer stall counter; a branch seen during a memory stall waits for IDLE.
  always_comb begin
    ctrl_cnt_d = ctrl_cnt_q;
    if (ctrl_hold) begin
      ctrl_cnt_d = ctrl_cnt_q - 2'd1;
    end else if (fill_q[0] && idle && (state_d == MemIdle) && is_ctrl(ir_op)) begin
      ctrl_cnt_d = 2'd3;
    end
  end

  // State registers; fill_q ramps the stage enables in one stage per cycle after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= MemIdle;
      ctrl_cnt_q <= 2'd0;
      fill_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      fill_q     <= {fill_q[1:0], 1'b1};
    end
  end

  lc3_bypass_logic u_bypass (
    .ir_op_i        (ir_op),
    .ir_dr_i        (bus.IR[11:9]),
    .ir_sr1_i       (bus.IR[8:6]),
    .ir_imm_i       (bus.IR[5]),
    .ir_sr2_i       (bus.IR[2:0]),
    .exec_op_i      (exec_op),
    .exec_dr_i      (bus.IR_Exec[11:9]),
    .mem_read_i     (state_q == MemRead),
    .bypass_alu_1_o (byp_alu_1),
    .bypass_alu_2_o (byp_alu_2),
    .bypass_mem_1_o (byp_mem_1),
    .bypass_mem_2_o (byp_mem_2)
  );

  // Outputs; reset low forces every enable, select and redirect to 0.
  always_comb begin
    bus.enable_decode    = reset && fill_q[0] && idle && !ctrl_hold;
    bus.enable_fetch     = bus.enable_decode && bus.complete_instr;
    bus.enable_updatePC  = bus.enable_decode && bus.complete_instr;
    // Execute stays open in the first control-stall cycle so the branch reaches execute.
    bus.enable_execute   = reset && fill_q[1] && idle && (!ctrl_hold || ctrl_cnt_q == 2'd3);
    bus.enable_writeback = reset && ((fill_q[2] && idle && !ctrl_hold) ||
                                     (state_q == MemRead && bus.complete_data));
    bus.br_taken         = reset && ((exec_op == OpJmp) ||
                                     (exec_op == OpBr && |(bus.NZP & bus.psr)));
    bus.bypass_alu_1     = reset && byp_alu_1;
    bus.bypass_alu_2     = reset && byp_alu_2;
    bus.bypass_mem_1     = reset && byp_mem_1;
    bus.bypass_mem_2     = reset && byp_mem_2;
  end

  // Map the internal state onto the externally visible encoding.
  always_comb begin
    bus.mem_state = IDLE_ST;
    unique case (state_q)
      MemRead:  bus.mem_state = READ_ST;
      MemInd:   bus.mem_state = IND_ST;
      MemWrite: bus.mem_state = WRITE_ST;
      default:  bus.mem_state = IDLE_ST;
    endcase
  end

endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// Directed self-checking bench for lc3_pipeline_ctrl.
module tb_lc3_pipeline_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   vec_count  = 0;
  int   miss_count = 0;

  lc3_pipeline_ctrl_if bus ();

  lc3_pipeline_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // {updatePC, fetch, decode, execute, writeback}
  logic [4:0] en;
  // {alu_1, alu_2, mem_1, mem_2}
  logic [3:0] byp;
  assign en  = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                bus.enable_execute, bus.enable_writeback};
  assign byp = {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2};

  task automatic quiet();
    bus.IR             = 16'h1000;  // ADD, non-control
    bus.IR_Exec        = 16'hE000;  // LEA, no memory access
    bus.complete_data  = 1'b0;
    bus.complete_instr = 1'b1;
    bus.NZP            = 3'b000;
    bus.psr            = 3'b000;
  endtask

  task automatic test_reset();
    logic [4:0] exp_en [3];
    exp_en = '{5'b11100, 5'b11110, 5'b11111};
    quiet();
    reset = 1'b0;
    @(negedge clock);
    vec_count++;
    if (en !== 5'b00000 || bus.mem_state !== 2'd3 || byp !== 4'b0000 || bus.br_taken !== 1'b0) begin
      miss_count++;
      $display("FAIL reset_values: en=%b state=%0d byp=%b br=%b, want en=00000 state=3 byp=0000 br=0",
               en, bus.mem_state, byp, bus.br_taken);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vec_count++;
      if (en !== exp_en[i] || bus.mem_state !== 2'd3) begin
        miss_count++;
        $display("FAIL reset_release_edge%0d: en=%b state=%0d, want en=%b state=3",
                 i + 1, en, bus.mem_state, exp_en[i]);
      end
    end
  endtask

  task automatic test_fetch_gating();
    @(negedge clock);
    bus.complete_instr = 1'b0;
    #1;
    vec_count++;
    if (en !== 5'b00111) begin
      miss_count++;
      $display("FAIL fetch_gated: en=%b, want 00111", en);
    end
    bus.complete_instr = 1'b1;
    #1;
    vec_count++;
    if (en !== 5'b11111) begin
      miss_count++;
      $display("FAIL fetch_ungated: en=%b, want 11111", en);
    end
  endtask

  task automatic test_alu_forward();
    logic [15:0] ir_tab  [6];
    logic [3:0]  exp_tab [6];
    ir_tab  = '{16'h1440, 16'h1081, 16'h3200, 16'h1061, 16'h7240, 16'hC040};
    exp_tab = '{4'b1000,  4'b0100,  4'b0100,  4'b1000,  4'b1100,  4'b1000};
    bus.IR_Exec = 16'h1261;  // ADD R1,R1,#1
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.IR = ir_tab[i];
      #1;
      vec_count++;
      if (byp !== exp_tab[i]) begin
        miss_count++;
        $display("FAIL alu_fwd IR=%h: byp=%b, want %b", ir_tab[i], byp, exp_tab[i]);
      end
    end
    @(negedge clock);
    quiet();
  endtask

  task automatic test_ld_bypass();
    @(negedge clock);
    bus.IR_Exec = 16'h2205;  // LD R1
    bus.IR      = 16'h1440;
    #1;
    vec_count++;
    if (byp !== 4'b0000 || bus.mem_state !== 2'd3) begin
      miss_count++;
      $display("FAIL ld_bypass_idle: byp=%b state=%0d, want 0000 state=3", byp, bus.mem_state);
    end
    @(negedge clock);
    #1;
    vec_count++;
    if (byp !== 4'b0010 || bus.mem_state !== 2'd0 || en !== 5'b00000) begin
      miss_count++;
      $display("FAIL ld_bypass_op1: byp=%b state=%0d en=%b, want 0010 state=0 en=00000",
               byp, bus.mem_state, en);
    end
    bus.IR = 16'h3200;  // ST R1
    #1;
    vec_count++;
    if (byp !== 4'b0001) begin
      miss_count++;
      $display("FAIL ld_bypass_op2: byp=%b, want 0001", byp);
    end
    bus.complete_data = 1'b1;
    bus.IR_Exec       = 16'hE000;
    @(negedge clock);
    bus.complete_data = 1'b0;
    #1;
    vec_count++;
    if (byp !== 4'b0000 || bus.mem_state !== 2'd3 || en !== 5'b11111) begin
      miss_count++;
      $display("FAIL ld_done: byp=%b state=%0d en=%b, want 0000 state=3 en=11111",
               byp, bus.mem_state, en);
    end
    quiet();
  endtask

  task automatic test_ldi();
    @(negedge clock);
    bus.IR_Exec = 16'hA205;  // LDI R1
    #1;
    vec_count++;
    if (en !== 5'b11111 || bus.mem_state !== 2'd3) begin
      miss_count++;
      $display("FAIL ldi_issue: en=%b state=%0d, want 11111 state=3", en, bus.mem_state);
    end
    @(negedge clock);
    bus.complete_data = 1'b1;
    #1;
    vec_count++;
    if (en !== 5'b00000 || bus.mem_state !== 2'd1) begin
      miss_count++;
      $display("FAIL ldi_ind: en=%b state=%0d, want 00000 state=1", en, bus.mem_state);
    end
    @(negedge clock);
    bus.complete_data = 1'b0;
    #1;
    vec_count++;
    if (en !== 5'b00000 || bus.mem_state !== 2'd0) begin
      miss_count++;
      $display("FAIL ldi_read_wait: en=%b state=%0d, want 00000 state=0", en, bus.mem_state);
    end
    @(negedge clock);
    bus.complete_data = 1'b1;
    bus.IR_Exec       = 16'hE000;
    #1;
    vec_count++;
    if (en !== 5'b00001 || bus.mem_state !== 2'd0) begin
      miss_count++;
      $display("FAIL ldi_read_done: en=%b state=%0d, want 00001 state=0", en, bus.mem_state);
    end
    @(negedge clock);
    bus.complete_data = 1'b0;
    #1;
    vec_count++;
    if (en !== 5'b11111 || bus.mem_state !== 2'd3) begin
      miss_count++;
      $display("FAIL ldi_resume: en=%b state=%0d, want 11111 state=3", en, bus.mem_state);
    end
  endtask

  task automatic test_sti_stall();
    @(negedge clock);
    bus.IR_Exec = 16'hB205;  // STI R1
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 4) bus.complete_data = 1'b1;
      #1;
      vec_count++;
      if (bus.mem_state !== 2'd1 || en !== 5'b00000) begin
        miss_count++;
        $display("FAIL sti_ind_cycle%0d: state=%0d en=%b, want state=1 en=00000",
                 i, bus.mem_state, en);
      end
    end
    @(negedge clock);
    bus.IR_Exec = 16'hE000;
    #1;
    vec_count++;
    if (bus.mem_state !== 2'd2 || en !== 5'b00000) begin
      miss_count++;
      $display("FAIL sti_write: state=%0d en=%b, want state=2 en=00000", bus.mem_state, en);
    end
    @(negedge clock);
    bus.complete_data = 1'b0;
    #1;
    vec_count++;
    if (bus.mem_state !== 2'd3 || en !== 5'b11111) begin
      miss_count++;
      $display("FAIL sti_idle: state=%0d en=%b, want state=3 en=11111", bus.mem_state, en);
    end
  endtask

  task automatic test_branch(input logic [2:0] psr_v, input logic exp_taken);
    logic [4:0] exp_en [4];
    exp_en = '{5'b00010, 5'b00000, 5'b00000, 5'b11111};
    @(negedge clock);
    bus.IR      = 16'h0E03;  // BRnzp in decode
    bus.IR_Exec = 16'hE000;
    bus.NZP     = 3'b111;
    bus.psr     = psr_v;
    #1;
    vec_count++;
    if (bus.br_taken !== 1'b0 || en !== 5'b11111) begin
      miss_count++;
      $display("FAIL br_decode psr=%b: br=%b en=%b, want br=0 en=11111", psr_v, bus.br_taken, en);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.IR      = 16'h1000;
      bus.IR_Exec = 16'h0E03;
      #1;
      vec_count++;
      if (en !== exp_en[i] || bus.br_taken !== exp_taken) begin
        miss_count++;
        $display("FAIL br_stall%0d psr=%b: en=%b br=%b, want en=%b br=%b",
                 i, psr_v, en, bus.br_taken, exp_en[i], exp_taken);
      end
    end
  endtask

  task automatic test_jmp();
    @(negedge clock);
    bus.IR_Exec = 16'hC1C0;  // JMP R7
    bus.psr     = 3'b000;
    #1;
    vec_count++;
    if (bus.br_taken !== 1'b1) begin
      miss_count++;
      $display("FAIL jmp_taken: br=%b, want 1", bus.br_taken);
    end
    quiet();
  endtask

  task automatic test_reset_mid_access();
    @(negedge clock);
    bus.IR_Exec = 16'h3205;  // ST R1
    @(negedge clock);
    bus.IR_Exec = 16'h1261;
    bus.IR      = 16'h1440;
    #1;
    vec_count++;
    if (bus.mem_state !== 2'd2) begin
      miss_count++;
      $display("FAIL mid_reset_pre: state=%0d, want 2", bus.mem_state);
    end
    #1;
    reset = 1'b0;
    #1;
    vec_count++;
    if (bus.mem_state !== 2'd3 || en !== 5'b00000 || byp !== 4'b0000) begin
      miss_count++;
      $display("FAIL mid_reset: state=%0d en=%b byp=%b, want state=3 en=00000 byp=0000",
               bus.mem_state, en, byp);
    end
    bus.IR_Exec = 16'hC1C0;
    #1;
    vec_count++;
    if (bus.br_taken !== 1'b0) begin
      miss_count++;
      $display("FAIL mid_reset_br: br=%b, want 0", bus.br_taken);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_gating();
    test_alu_forward();
    test_ld_bypass();
    test_ldi();
    test_sti_stall();
    test_branch(3'b010, 1'b1);
    test_branch(3'b000, 1'b0);
    test_jmp();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
